// File: rtl/led_frame_sequencer_pkg.sv
// Shared types and constants for the LED frame sequencer.
// Pixel words: even word {R,G}, odd word {B,8'h00}.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    CAPTURE,
    LOAD,
    WAIT_DONE,
    LATCH
  } seq_state_t;

  localparam int PIX_WORDS = 2;
  localparam int B_MSB     = 15;
  localparam int B_LSB     = 8;

  localparam int DEFAULT_LATCH = 3000;

  localparam logic [3:0] WE_ALL  = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Host write channel and SPRAM port of the LED frame sequencer.
// master = sequencer side, slave = host plus SPRAM side.
interface led_frame_sequencer_if #(
  parameter int ADDR_W = 14
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport master (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/led_frame_sequencer_spram_arbiter.sv
// Single SPRAM port shared by pixel fetches and host writes.
// Host writes win whenever the sequencer is not fetching.
module spram_arbiter
  import led_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sequencer_owns_port,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [15:0]       mem_wdata
);

  logic [ADDR_W-1:0] addr_q;
  logic              grant;

  assign grant  = reset & wr_req & ~sequencer_owns_port;
  assign wr_ack = grant;

  // Address parks on its last value when nobody uses the port.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = WE_NONE;
    mem_wdata = '0;
    unique case (1'b1)
      grant: begin
        mem_addr  = wr_addr;
        mem_we    = WE_ALL;
        mem_wdata = wr_data;
      end
      sequencer_owns_port: begin
        mem_addr = seq_addr;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= mem_addr;
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame controller: fetches pixels from SPRAM, hands them to the
// LED driver one at a time, then holds the latch gap.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 14,
  parameter int LATCH_CYCLES = DEFAULT_LATCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [23:0] rgb,
  output logic        load,
  input  logic        drv_done,
  led_frame_sequencer_if.master bus
);

  localparam int IDX_W =
    (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W =
    (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(LATCH_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rg_q, rg_d;
  logic [23:0]       rgb_q, rgb_d;

  logic              owns;
  logic [IDX_W:0]    word_off;
  logic [ADDR_W-1:0] seq_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rg_q    <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rg_q    <= rg_d;
      rgb_q   <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rg_d    = rg_q;
    rgb_d   = rgb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = FETCH_HI;
        end
      end
      FETCH_HI: begin
        state_d = FETCH_LO;
      end
      FETCH_LO: begin
        rg_d    = bus.mem_rdata;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rgb_d   = {rg_q, bus.mem_rdata[B_MSB:B_LSB]};
        state_d = LOAD;
      end
      LOAD: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (drv_done) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = LATCH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH_HI;
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign load       = (state_q == LOAD);
  assign rgb        = rgb_q;
  assign frame_done = (state_q == LATCH) &&
                      (cnt_q == LAST_CNT);

  // Word address is 2*idx, plus one for the blue word.
  assign owns     = (state_q == FETCH_HI) ||
                    (state_q == FETCH_LO);
  assign word_off = {idx_q, state_q == FETCH_LO};
  assign seq_addr = ADDR_W'(word_off);

  spram_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .clk                 (clk),
    .reset               (reset),
    .sequencer_owns_port (owns),
    .seq_addr            (seq_addr),
    .wr_req              (bus.wr_req),
    .wr_addr             (bus.wr_addr),
    .wr_data             (bus.wr_data),
    .wr_ack              (bus.wr_ack),
    .mem_addr            (bus.mem_addr),
    .mem_we              (bus.mem_we),
    .mem_wdata           (bus.mem_wdata)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: a 3-pixel and a 1-pixel instance
// share a clock; each has its own SPRAM model and host driver.
`timescale 1ns/1ps
module tb_led_frame_sequencer;
  import led_pkg::*;

  localparam int AW = 14;
  localparam int NA = 3;
  localparam int LA = 5;
  localparam int NB = 1;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0;
  logic        dd_a = 1'b0;
  logic        busy_a, fd_a, load_a;
  logic [23:0] rgb_a;
  logic        start_b = 1'b0;
  logic        dd_b = 1'b0;
  logic        busy_b, fd_b, load_b;
  logic [23:0] rgb_b;

  led_frame_sequencer_if #(.ADDR_W(AW)) bus_a ();
  led_frame_sequencer_if #(.ADDR_W(AW)) bus_b ();

  led_frame_sequencer #(
    .NUM_LEDS(NA), .ADDR_W(AW), .LATCH_CYCLES(LA)
  ) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a),
    .busy(busy_a), .frame_done(fd_a), .rgb(rgb_a),
    .load(load_a), .drv_done(dd_a), .bus(bus_a)
  );

  led_frame_sequencer #(
    .NUM_LEDS(NB), .ADDR_W(AW), .LATCH_CYCLES(LB)
  ) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b),
    .busy(busy_b), .frame_done(fd_b), .rgb(rgb_b),
    .load(load_b), .drv_done(dd_b), .bus(bus_b)
  );

  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];

  always @(posedge clk) begin
    if (bus_a.mem_we == 4'hF)
      mem_a[bus_a.mem_addr[5:0]] <= bus_a.mem_wdata;
    bus_a.mem_rdata <= mem_a[bus_a.mem_addr[5:0]];
    if (bus_b.mem_we == 4'hF)
      mem_b[bus_b.mem_addr[5:0]] <= bus_b.mem_wdata;
    bus_b.mem_rdata <= mem_b[bus_b.mem_addr[5:0]];
  end

  int checks = 0;
  int errors = 0;

  logic [15:0]   img_a [0:5];
  logic [15:0]   img_b [0:1];
  logic [AW-1:0] wq_addr [$];
  logic [15:0]   wq_data [$];

  task automatic drive_wr(input bit sel, input logic r,
                          input logic [AW-1:0] a,
                          input logic [15:0] d);
    if (sel) begin
      bus_b.wr_req = r; bus_b.wr_addr = a; bus_b.wr_data = d;
    end else begin
      bus_a.wr_req = r; bus_a.wr_addr = a; bus_a.wr_data = d;
    end
  endtask

  // Host writes of the image through the DUT while it is idle.
  task automatic preload(input bit sel, input int n);
    logic ack;
    logic [15:0] d;
    for (int w = 0; w < n; w++) begin
      @(posedge clk); #1;
      d = sel ? img_b[w] : img_a[w];
      drive_wr(sel, 1'b1, AW'(w), d);
      @(negedge clk);
      ack = sel ? bus_b.wr_ack : bus_a.wr_ack;
      checks++;
      if (ack !== 1'b1) begin
        errors++;
        $display("FAIL idle_ack sel=%0d w=%0d got %b want 1",
                 sel, w, ack);
      end
    end
    @(posedge clk); #1;
    drive_wr(sel, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_a, fd_a, load_a, bus_a.wr_ack,
         busy_b, fd_b, load_b, bus_b.wr_ack} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b %b%b%b%b want 0",
               busy_a, fd_a, load_a, bus_a.wr_ack,
               busy_b, fd_b, load_b, bus_b.wr_ack);
    end
    checks++;
    if ({rgb_a, rgb_b} !== 48'h0) begin
      errors++;
      $display("FAIL reset_rgb got %h %h want 0", rgb_a, rgb_b);
    end
    checks++;
    if ({bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata,
         bus_b.mem_addr, bus_b.mem_we, bus_b.mem_wdata} !== '0)
    begin
      errors++;
      $display("FAIL reset_mem got %h/%h/%h %h/%h/%h want 0",
               bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata,
               bus_b.mem_addr, bus_b.mem_we, bus_b.mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel(input logic [15:0] w0,
                                   input logic [15:0] w1);
    logic [23:0] exp;
    img_b[0] = w0;
    img_b[1] = w1;
    preload(1'b1, 2);
    exp = {w0, w1[15:8]};
    @(posedge clk); #1;
    for (int c = 0; c <= 16; c++) begin
      start_b = (c == 0);
      dd_b    = (c == 10);
      @(negedge clk);
      checks++;
      if (load_b !== (c == 4)) begin
        errors++;
        $display("FAIL sp_load c=%0d got %b", c, load_b);
      end
      if (c == 4) begin
        checks++;
        if (rgb_b !== exp) begin
          errors++;
          $display("FAIL sp_rgb got %h want %h", rgb_b, exp);
        end
      end
      checks++;
      if (fd_b !== (c == 14)) begin
        errors++;
        $display("FAIL sp_done c=%0d got %b", c, fd_b);
      end
      checks++;
      if (busy_b !== (c >= 1 && c <= 14)) begin
        errors++;
        $display("FAIL sp_busy c=%0d got %b", c, busy_b);
      end
      @(posedge clk); #1;
    end
    start_b = 1'b0;
    dd_b = 1'b0;
  endtask

  // One frame on the 3-pixel DUT. Cycle 0 carries start; pending
  // writes in wq_* are offered from cycle wr_from on.
  task automatic run_frame(input int dly, input bit spur,
                           input int wr_from);
    logic [15:0]   w [0:5];
    logic [23:0]   exp_rgb [0:2];
    logic [AW-1:0] hist [0:1023];
    logic [AW-1:0] wa [$];
    logic [15:0]   wd [$];
    int cyc, exp_load, dd_at, ld_last, fd_cyc;
    int nloads, nfd, lim;
    bit req, own, expb;

    for (int i = 0; i < 6; i++) w[i] = img_a[i];
    foreach (wq_addr[i])
      if (wq_addr[i] < 6) w[wq_addr[i][2:0]] = wq_data[i];
    for (int p = 0; p < 3; p++)
      exp_rgb[p] = {w[2*p], w[2*p+1][15:8]};
    wa = wq_addr;
    wd = wq_data;

    exp_load = 4; dd_at = -100; ld_last = -100; fd_cyc = -1;
    nloads = 0; nfd = 0;
    lim = 3 * (dly + 6) + 40;
    cyc = -2;
    @(posedge clk); #1;
    while (cyc < lim && !(fd_cyc >= 0 && cyc > fd_cyc + 1)) begin
      req = (cyc >= wr_from) && (wq_addr.size() > 0);
      if (req) drive_wr(1'b0, 1'b1, wq_addr[0], wq_data[0]);
      else     drive_wr(1'b0, 1'b0, '0, '0);
      start_a = (cyc == 0) ||
                (spur && cyc == ld_last + 1 && cyc < dd_at);
      dd_a = (cyc == dd_at) || (spur && cyc == exp_load - 2);
      own = (nloads < 3) &&
            (cyc == exp_load - 3 || cyc == exp_load - 2);
      @(negedge clk);
      hist[cyc+2] = bus_a.mem_addr;
      expb = (cyc >= 1) && (fd_cyc < 0);
      checks++;
      if (busy_a !== expb) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b",
                 cyc, busy_a, expb);
      end
      checks++;
      if (bus_a.wr_ack !== (req && !own)) begin
        errors++;
        $display("FAIL wr_ack cyc=%0d got %b want %b",
                 cyc, bus_a.wr_ack, req && !own);
      end
      if (bus_a.wr_ack === 1'b1 && req) begin
        checks++;
        if (bus_a.mem_we !== 4'hF ||
            bus_a.mem_addr !== wq_addr[0] ||
            bus_a.mem_wdata !== wq_data[0]) begin
          errors++;
          $display("FAIL grant_bus cyc=%0d got %h/%h/%h want F/%h/%h",
                   cyc, bus_a.mem_we, bus_a.mem_addr,
                   bus_a.mem_wdata, wq_addr[0], wq_data[0]);
        end
        void'(wq_addr.pop_front());
        void'(wq_data.pop_front());
      end else begin
        checks++;
        if (bus_a.mem_we !== 4'h0) begin
          errors++;
          $display("FAIL mem_we_idle cyc=%0d got %h want 0",
                   cyc, bus_a.mem_we);
        end
      end
      if (load_a === 1'b1) begin
        checks++;
        if (nloads >= 3 || cyc != exp_load) begin
          errors++;
          $display("FAIL load_time cyc=%0d want %0d n=%0d",
                   cyc, exp_load, nloads);
        end else begin
          checks++;
          if (rgb_a !== exp_rgb[nloads]) begin
            errors++;
            $display("FAIL rgb p=%0d got %h want %h",
                     nloads, rgb_a, exp_rgb[nloads]);
          end
          checks++;
          if (hist[cyc-1] !== AW'(2*nloads) ||
              hist[cyc] !== AW'(2*nloads+1)) begin
            errors++;
            $display("FAIL fetch_addr p=%0d got %0d,%0d want %0d,%0d",
                     nloads, hist[cyc-1], hist[cyc],
                     2*nloads, 2*nloads+1);
          end
          nloads++;
          ld_last = cyc;
          dd_at = cyc + dly;
          exp_load = dd_at + 4;
        end
      end else if (nloads > 0) begin
        checks++;
        if (rgb_a !== exp_rgb[nloads-1]) begin
          errors++;
          $display("FAIL rgb_hold cyc=%0d got %h want %h",
                   cyc, rgb_a, exp_rgb[nloads-1]);
        end
      end
      if (fd_a === 1'b1) begin
        nfd++;
        checks++;
        if (nloads != 3 || cyc != dd_at + LA) begin
          errors++;
          $display("FAIL done_time cyc=%0d want %0d",
                   cyc, dd_at + LA);
        end
        if (fd_cyc < 0) fd_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0;
    dd_a = 1'b0;
    drive_wr(1'b0, 1'b0, '0, '0);
    checks++;
    if (nfd != 1 || nloads != 3) begin
      errors++;
      $display("FAIL frame_count loads=%0d dones=%0d want 3/1",
               nloads, nfd);
    end
    checks++;
    if (wq_addr.size() != 0) begin
      errors++;
      $display("FAIL writes_left got %0d want 0", wq_addr.size());
      wq_addr.delete();
      wq_data.delete();
    end
    foreach (wa[i]) begin
      checks++;
      if (mem_a[wa[i][5:0]] !== wd[i]) begin
        errors++;
        $display("FAIL wr_commit a=%0d got %h want %h",
                 wa[i], mem_a[wa[i][5:0]], wd[i]);
      end
    end
    for (int i = 0; i < 6; i++) img_a[i] = w[i];
  endtask

  task automatic new_image_a;
    for (int i = 0; i < 6; i++) img_a[i] = 16'($urandom);
    preload(1'b0, 6);
  endtask

  task automatic test_three_pixel;
    new_image_a();
    run_frame(20, 1'b0, 0);
  endtask

  task automatic test_arbitration;
    new_image_a();
    wq_addr.push_back(AW'(5));
    wq_data.push_back(16'h1234);
    run_frame(8, 1'b0, 1);
  endtask

  task automatic test_spurious;
    new_image_a();
    run_frame(6, 1'b1, 0);
  endtask

  task automatic test_idle_writes;
    new_image_a();
    for (int i = 0; i < 3; i++) begin
      wq_addr.push_back(AW'(40 + i));
      wq_data.push_back(16'($urandom));
    end
    run_frame(5, 1'b0, -1);
  endtask

  task automatic test_reset_mid_frame;
    new_image_a();
    @(posedge clk); #1;
    for (int c = 0; c <= 30; c++) begin
      start_a = (c == 0);
      dd_a    = (c == 6 || c == 12);
      rst_n   = (c != 17);
      @(negedge clk);
      if (c == 16) begin
        checks++;
        if (load_a !== 1'b1) begin
          errors++;
          $display("FAIL rst_pre_load got %b want 1", load_a);
        end
      end
      if (c == 18) begin
        checks++;
        if ({busy_a, fd_a, load_a, bus_a.wr_ack} !== 4'h0 ||
            rgb_a !== 24'h0 || bus_a.mem_addr !== '0 ||
            bus_a.mem_we !== 4'h0 || bus_a.mem_wdata !== 16'h0)
        begin
          errors++;
          $display("FAIL rst_mid got %b%b%b%b %h %h %h %h want 0",
                   busy_a, fd_a, load_a, bus_a.wr_ack, rgb_a,
                   bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata);
        end
      end
      if (c >= 18) begin
        checks++;
        if (fd_a !== 1'b0 || busy_a !== 1'b0) begin
          errors++;
          $display("FAIL rst_after c=%0d got fd=%b busy=%b want 0",
                   c, fd_a, busy_a);
        end
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    dd_a = 1'b0;
    rst_n = 1'b1;
    run_frame(4, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 4; f++) begin
      if (f[0]) new_image_a();
      run_frame(int'($urandom_range(2, 12)),
                1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    drive_wr(1'b0, 1'b0, '0, '0);
    drive_wr(1'b1, 1'b0, '0, '0);
    test_reset();
    test_single_pixel(16'hA1B2, 16'hC3FF);
    test_single_pixel(16'($urandom), 16'($urandom));
    test_three_pixel();
    test_arbitration();
    test_spurious();
    test_idle_writes();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
